ps2_kb_decoder: RTL

//   Sits directly downstream of the PS/2 byte receiver. It consumes each received scan-code byte
//   and folds the E0 (extended) and F0 (break) prefixes into a single key event.
//   It keeps a live modifier-key bitmap and buffers the events in a small FIFO.

---
 rtl/ps2_kb_decoder_pkg.sv | 45 ++++
 rtl/ps2_kb_decoder_if.sv | 24 ++
 rtl/ps2_evt_fifo.sv | 43 ++++
 rtl/ps2_kb_decoder.sv | 95 +++++++++
 4 files changed

// File: rtl/ps2_kb_decoder_pkg.sv
// Shared scan-code constants, event layout and FSM state type for the PS/2 key decoder.
// Also holds the modifier-key lookup used to maintain the live modifier bitmap.
package ps2_kb_decoder_pkg;

  localparam int EV_W   = 10;
  localparam int EV_EXT = 9;
  localparam int EV_BRK = 8;
  localparam int MODS_W = 6;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  // Bit positions inside mods: {ralt, lalt, rctrl, lctrl, rshift, lshift}
  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_LCTRL  = 2;
  localparam int MOD_RCTRL  = 3;
  localparam int MOD_LALT   = 4;
  localparam int MOD_RALT   = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PFX  = 1'b1
  } state_e;

  // One-hot selector of the modifier bit touched by (ext, code); zero for other keys.
  function automatic logic [MODS_W-1:0] mod_mask(input logic ext, input logic [7:0] code);
    logic [MODS_W-1:0] m;
    m = '0;
    if (!ext && code == SC_LSHIFT) m[MOD_LSHIFT] = 1'b1;
    if (!ext && code == SC_RSHIFT) m[MOD_RSHIFT] = 1'b1;
    if (!ext && code == SC_CTRL)   m[MOD_LCTRL]  = 1'b1;
    if ( ext && code == SC_CTRL)   m[MOD_RCTRL]  = 1'b1;
    if (!ext && code == SC_ALT)    m[MOD_LALT]   = 1'b1;
    if ( ext && code == SC_ALT)    m[MOD_RALT]   = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ps2_kb_decoder_if.sv
// Bus between the PS/2 key decoder and its environment: byte strobe in, event FIFO and status out.
interface ps2_kb_decoder_if;
  import ps2_kb_decoder_pkg::*;

  logic              scan_done_tick;
  logic [7:0]        scan_code;
  logic              ev_rd;
  logic [EV_W-1:0]   ev_data;
  logic              ev_empty;
  logic              ev_full;
  logic              overflow;
  logic [MODS_W-1:0] mods;

  modport master (
    output scan_done_tick, scan_code, ev_rd,
    input  ev_data, ev_empty, ev_full, overflow, mods
  );

  modport slave (
    input  scan_done_tick, scan_code, ev_rd,
    output ev_data, ev_empty, ev_full, overflow, mods
  );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra MSB to tell full from empty.
module ps2_evt_fifo #(
  parameter int DW = 10,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [AW:0]   wptr_q, rptr_q;
  logic [DW-1:0] mem_q [2**AW];
  logic          wr_en, rd_en;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A write into a full FIFO is only allowed when the head leaves in the same cycle.
    wr_en   = wr_i && (!full_o || rd_i);
    rd_en   = rd_i && !empty_o;
    rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_kb_decoder.sv
// Folds E0/F0 prefixes into single key events, tracks held modifier keys and queues the events.
module ps2_kb_decoder
  import ps2_kb_decoder_pkg::*;
#(
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TMR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  ps2_kb_decoder_if.slave  bus
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic              ext_q, brk_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [MODS_W-1:0] mods_q, mods_d, mask;
  logic              ovf_q;

  logic              is_pfx, is_err, wr_ev;
  logic [EV_W-1:0]   ev_wdata, fifo_rdata;
  logic              fifo_empty, fifo_full;

  always_comb begin
    is_pfx   = (bus.scan_code == SC_EXT) || (bus.scan_code == SC_BRK);
    is_err   = (bus.scan_code == SC_ERR0) || (bus.scan_code == SC_ERR1);
    wr_ev    = bus.scan_done_tick && !is_pfx && !is_err;
    ev_wdata = {ext_q, brk_q, bus.scan_code};
    mask     = mod_mask(ext_q, bus.scan_code);
    // Modifiers follow every emitted event, even one the FIFO has to drop.
    mods_d   = mods_q;
    if (wr_ev) mods_d = (mods_q & ~mask) | (mask & {MODS_W{~brk_q}});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      tmr_q   <= '0;
      mods_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.scan_done_tick) begin
        tmr_q <= '0;
        if (bus.scan_code == SC_EXT) begin
          ext_q   <= 1'b1;
          state_q <= ST_PFX;
        end else if (bus.scan_code == SC_BRK) begin
          brk_q   <= 1'b1;
          state_q <= ST_PFX;
        end else begin
          ext_q   <= 1'b0;
          brk_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      end else if (state_q == ST_PFX) begin
        // A stale prefix is abandoned so a lost byte cannot corrupt the next key.
        if (tmr_q == TMO_LAST) begin
          ext_q   <= 1'b0;
          brk_q   <= 1'b0;
          tmr_q   <= '0;
          state_q <= ST_IDLE;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
      end
      mods_q <= mods_d;
      if (wr_ev && fifo_full && !bus.ev_rd) ovf_q <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .DW (EV_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (wr_ev),
    .wdata_i (ev_wdata),
    .rd_i    (bus.ev_rd),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.ev_data  = fifo_rdata;
  assign bus.ev_empty = fifo_empty;
  assign bus.ev_full  = fifo_full;
  assign bus.overflow = ovf_q;
  assign bus.mods     = mods_q;

endmodule
